// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic port_t;

   localparam port_t PORT_I = 1'b0;
   localparam port_t PORT_D = 1'b1;

   localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the port not granted last.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic  req_i,
   input  logic  req_d,
   input  port_t last_grant,
   output port_t grant
);

   always_comb begin
      if (req_i && req_d) begin
         grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
      end else if (req_d) begin
         grant = PORT_D;
      end else begin
         grant = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory interface,
// one access at a time, with a wait-cycle timeout that aborts stalled accesses.
//
//   state | meaning
//   IDLE  | no access in flight, arbitrate on incoming requests
//   BUSY  | strobe asserted with latched address/data, waiting for mem_ready
//   RESP  | one-cycle ack to the granted port, err reports a timeout
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

   state_t      state_q, state_d;
   port_t       port_q, port_d;
   port_t       last_grant_q, last_grant_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        err_q, err_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   port_t       grant;

   arb_rr2 u_arb (
      .req_i      (i_req),
      .req_d      (d_req),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      mem_rd_d     = 1'b0;
      mem_wr_d     = 1'b0;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      err_d        = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d      = BUSY;
               port_d       = grant;
               last_grant_d = grant;
               we_d         = (grant == PORT_D) && d_we;
               addr_d       = (grant == PORT_D) ? d_addr : i_addr;
               wdata_d      = (grant == PORT_D) ? d_wdata : 32'd0;
               cnt_d        = 8'd0;
               mem_rd_d     = !we_d;
               mem_wr_d     = we_d;
            end
         end
         BUSY: begin
            // mem_ready wins over a timeout landing on the same cycle
            if (mem_ready) begin
               state_d = RESP;
               i_ack_d = (port_q == PORT_I);
               d_ack_d = (port_q == PORT_D);
               if (!we_q) begin
                  if (port_q == PORT_I) begin
                     i_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end else if (cnt_q + 8'd1 == TO_CNT) begin
               state_d = RESP;
               cnt_d   = cnt_q + 8'd1;
               i_ack_d = (port_q == PORT_I);
               d_ack_d = (port_q == PORT_D);
               err_d   = 1'b1;
            end else begin
               cnt_d    = cnt_q + 8'd1;
               mem_rd_d = mem_rd_q;
               mem_wr_d = mem_wr_q;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         port_q       <= PORT_I;
         last_grant_q <= PORT_D;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         cnt_q        <= 8'd0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         err_q        <= 1'b0;
         i_rdata_q    <= 32'd0;
         d_rdata_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         port_q       <= port_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         err_q        <= err_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign err       = err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected acks are queued by the stimulus and
// popped by an independent monitor whenever the DUT pulses i_ack or d_ack.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'd0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [31:0] d_wdata = 32'd0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        err;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ready = 1'b0;

   mem_arbiter #(.TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .err       (err),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          ack_cnt = 0;

   // memory responder: raises mem_ready after ready_wait strobe cycles
   int          ready_wait = 0;
   logic [31:0] rdata_val = 32'd0;
   int          busy_cyc = 0;
   int          last_len = 0;
   logic        unstable = 1'b0;
   logic [31:0] cap_addr, cap_wdata;

   always @(negedge clk) begin
      if (mem_rd || mem_wr) begin
         if (busy_cyc == 0) begin
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
         end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
            unstable = 1'b1;
         end
         mem_rdata = rdata_val;
         mem_ready = (busy_cyc == ready_wait);
         busy_cyc  = busy_cyc + 1;
      end else begin
         if (busy_cyc != 0) last_len = busy_cyc;
         busy_cyc  = 0;
         mem_ready = 1'b0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      logic [31:0] act_rd;
      if (!rst && (i_ack || d_ack)) begin
         ack_cnt = ack_cnt + 1;
         n_vec   = n_vec + 1;
         if (i_ack && d_ack) begin
            n_err = n_err + 1;
            $display("FAIL dual_ack: i_ack=%b d_ack=%b required one", i_ack, d_ack);
         end else if (sb.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL unexpected_ack: i_ack=%b d_ack=%b required none", i_ack, d_ack);
         end else begin
            e = sb.pop_front();
            act_rd = d_ack ? d_rdata : i_rdata;
            if (d_ack !== e.port || err !== e.err || act_rd !== e.rdata) begin
               n_err = n_err + 1;
               $display("FAIL ack_compare: got port=%b err=%b rdata=%h required port=%b err=%b rdata=%h",
                        d_ack, err, act_rd, e.port, e.err, e.rdata);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic port, input logic e, input logic [31:0] rd);
      exp_t x;
      x.port  = port;
      x.err   = e;
      x.rdata = rd;
      sb.push_back(x);
   endtask

   task automatic wait_acks(input string nm, input int n);
      int start;
      int c;
      start = ack_cnt;
      c = 0;
      while (ack_cnt < start + n && c < 400) begin
         @(posedge clk);
         c++;
      end
      chk(nm, 32'(ack_cnt - start), 32'(n));
   endtask

   // single request; checks strobes/address on the grant cycle, then
   // scrambles inputs and drops the request to show the access is latched
   task automatic issue(input string nm, input logic is_d, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge clk) #2;
      unstable = 1'b0;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      @(posedge clk) #1;
      chk({nm, "_rd"},   32'(mem_rd), 32'(!we));
      chk({nm, "_wr"},   32'(mem_wr), 32'(we));
      chk({nm, "_addr"}, mem_addr, addr);
      if (we) chk({nm, "_wdata"}, mem_wdata, wdata);
      i_req = 1'b0; d_req = 1'b0;
      d_we = ~we; d_addr = ~addr; d_wdata = ~wdata; i_addr = ~addr;
   endtask

   initial begin
      #23;
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_acks",   32'({i_ack, d_ack, err}), 32'd0);
      chk("rst_rdata",  i_rdata | d_rdata | mem_addr | mem_wdata, 32'd0);
      @(posedge clk) #2;
      rst = 1'b0;

      // fetch, memory ready immediately
      ready_wait = 0; rdata_val = 32'h8C010004;
      push(PORT_I, 1'b0, 32'h8C010004);
      issue("fetch", 1'b0, 1'b0, 32'h00000040, 32'd0);
      @(posedge clk) #1;
      chk("fetch_ack_latency", 32'(i_ack), 32'd1);
      chk("fetch_d_ack_quiet", 32'(d_ack), 32'd0);
      repeat (2) @(posedge clk);

      // write with three wait cycles
      ready_wait = 3; rdata_val = 32'hDEADDEAD;
      push(PORT_D, 1'b0, 32'h00000000);
      issue("write", 1'b1, 1'b1, 32'h00000100, 32'hCAFEF00D);
      wait_acks("write_ack", 1);
      @(posedge clk) #1;
      chk("write_strobe_len", 32'(last_len), 32'd4);
      chk("write_stable",     32'(unstable), 32'd0);
      chk("write_d_rdata",    d_rdata, 32'h00000000);

      // continuous tie: I, D, I, D
      ready_wait = 0; rdata_val = 32'h1234ABCD;
      push(PORT_I, 1'b0, 32'h1234ABCD);
      push(PORT_D, 1'b0, 32'h1234ABCD);
      push(PORT_I, 1'b0, 32'h1234ABCD);
      push(PORT_D, 1'b0, 32'h1234ABCD);
      @(posedge clk) #2;
      i_req = 1'b1; i_addr = 32'h00001000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00002000;
      wait_acks("tie_acks", 4);
      #2;
      i_req = 1'b0; d_req = 1'b0;
      repeat (2) @(posedge clk);

      // read timeout: d_rdata must keep the tie-phase value
      ready_wait = 99; rdata_val = 32'hBAD0BAD0;
      push(PORT_D, 1'b1, 32'h1234ABCD);
      issue("tmo", 1'b1, 1'b0, 32'h00000300, 32'd0);
      wait_acks("tmo_ack", 1);
      @(posedge clk) #1;
      chk("tmo_strobe_len", 32'(last_len), 32'd15);
      chk("tmo_stable",     32'(unstable), 32'd0);

      // mem_ready on the timeout cycle wins
      ready_wait = 14; rdata_val = 32'h5A5A0F0F;
      push(PORT_D, 1'b0, 32'h5A5A0F0F);
      issue("simul", 1'b1, 1'b0, 32'h00000304, 32'd0);
      wait_acks("simul_ack", 1);
      @(posedge clk) #1;
      chk("simul_strobe_len", 32'(last_len), 32'd15);

      // fetch so last grant is I, then reset during a data access
      ready_wait = 0; rdata_val = 32'h0BADBEEF;
      push(PORT_I, 1'b0, 32'h0BADBEEF);
      issue("pre_rst", 1'b0, 1'b0, 32'h00000080, 32'd0);
      wait_acks("pre_rst_ack", 1);
      ready_wait = 99;
      issue("mid_rst", 1'b1, 1'b0, 32'h00000400, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_strobe_drop", 32'({mem_rd, mem_wr}), 32'd0);
      chk("rst_i_rdata_clr", i_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk("rst_no_stray_ack", 32'(sb.size()), 32'd0);

      ready_wait = 0; rdata_val = 32'h77770001;
      push(PORT_I, 1'b0, 32'h77770001);
      @(posedge clk) #2;
      i_req = 1'b1; i_addr = 32'h00000200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000500;
      @(posedge clk) #1;
      chk("post_rst_tie_addr", mem_addr, 32'h00000200);
      chk("post_rst_tie_rd",   32'(mem_rd), 32'd1);
      i_req = 1'b0; d_req = 1'b0;
      wait_acks("post_rst_ack", 1);
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum wait cycles for mem_ready before an access is aborted (legal range 1..255).
REQ-002 Port: clk  in  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: i_req  in  1  instruction-fetch read request.
REQ-005 Port: i_addr  in  32  fetch address.
REQ-006 Port: i_ack  out  1  one-cycle fetch completion pulse.
REQ-007 Port: i_rdata  out  32  fetch data, valid with i_ack, held until the next fetch completes.
REQ-008 Port: d_req  in  1  data-port request.
REQ-009 Port: d_we  in  1  data-port write (1) or read (0).
REQ-010 Port: d_addr  in  32  data-port address.
REQ-011 Port: d_wdata  in  32  data-port write data.
REQ-012 Port: d_ack  out  1  one-cycle data completion pulse.
REQ-013 Port: d_rdata  out  32  data read result, valid with d_ack, held until the next data read completes.
REQ-014 Port: err  out  1  timeout flag, valid only with i_ack or d_ack.
REQ-015 Port: mem_rd  out  1  memory read strobe.
REQ-016 Port: mem_wr  out  1  memory write strobe.
REQ-017 Port: mem_addr  out  32  memory address.
REQ-018 Port: mem_wdata  out  32  memory write data.
REQ-019 Port: mem_rdata  in  32  memory read data, sampled when mem_ready=1.
REQ-020 Port: mem_ready  in  1  memory completion indication.

Function
REQ-021 FSM SHALL have three states: IDLE, BUSY, RESP.
- IDLE -> BUSY on any request.
- BUSY -> RESP on mem_ready or timeout.
- RESP -> IDLE unconditionally.
REQ-022 In IDLE with exactly one request, the block SHALL grant it.
- Both requests present: grant the port not granted last (round-robin).
- last_grant reset value = D, so I wins the first tie.
REQ-023 On grant, the block SHALL latch into internal registers: port ID, address, write flag (0 for I), and write data.
REQ-024 In BUSY, mem_addr/mem_wdata SHALL equal the latched values and be stable.
- mem_rd = !we; mem_wr = we.
- Both strobes are 0 in IDLE and RESP; never both 1.
REQ-025 BUSY SHALL increment an 8-bit wait counter each cycle mem_ready=0.
- The counter clears on entry to BUSY.
- Counter reaching TIMEOUT -> RESP with err=1.
REQ-026 mem_ready=1 in BUSY SHALL take priority over a simultaneous timeout: go to RESP with err=0.
- On a read, capture mem_rdata into the granted port's rdata register.
REQ-027 In RESP, the block SHALL pulse the granted port's ack for one cycle; the other ack stays 0.
REQ-028 Minimum latency SHALL be: request sampled at edge N, strobe high in cycle N+1, ack high in cycle N+2 (when mem_ready=1 in N+1).
REQ-029 Writes and timed-out reads SHALL leave rdata registers unchanged.
REQ-030 A request still asserted in the cycle after ack SHALL be treated as a new request.
REQ-031 Request deassertion during BUSY SHALL NOT abort the access; ack still pulses.
REQ-032 Input changes on addr/wdata/we after the grant SHALL be ignored.

Reset
REQ-033 rst=1 SHALL immediately (asynchronously) force:
- state=IDLE, counter=0, last_grant=D;
- all outputs 0, including rdata registers.
REQ-034 Reset mid-access SHALL abandon the transaction with no ack and no strobe.

Structure
REQ-035 State encoding, port-ID constants (PORT_I, PORT_D) and the TIMEOUT default SHALL live in shared package mem_arb_pkg.
REQ-036 Two-way round-robin grant logic SHALL be a sub-module arb_rr2 (inputs: two requests, last_grant; output: grant ID).

Verification
REQ-037 Directed scenarios:
- Fetch, ready immediate: i_req, i_addr=0x00000040, mem_rdata=0x8C010004 -> mem_rd in cycle+1, i_ack=1 and i_rdata=0x8C010004 in cycle+2, err=0.
- Write: d_req, d_we=1, d_addr=0x100, d_wdata=0xCAFEF00D, ready after 3 waits -> mem_wr high for 4 cycles with stable addr/data, then d_ack; d_rdata unchanged.
- Tie: i_req and d_req held continuously -> grants alternate I, D, I, D.
- Timeout: TIMEOUT=15, mem_ready held 0 -> RESP after 15 wait cycles; d_ack=1, err=1, d_rdata unchanged.
- Simultaneous: mem_ready=1 on the timeout cycle -> err=0, data captured.
- Reset: rst asserted in BUSY -> strobes drop immediately, no ack, next tie grants I.
